// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and the constants used when committing special-case divide results.
package hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_e;

    // Widest supported WIDTH; the divide-by-zero quotient is sliced from this.
    localparam int                   MAX_WIDTH = 256;
    localparam logic [MAX_WIDTH-1:0] DIV0_LO   = '1;

    function automatic logic is_signed_op(input logic [2:0] op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between ID/EX and the HI/LO multiply/divide unit.
// The pipeline side is the master; the unit itself is the slave.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             WrHI;
    logic             WrLO;
    logic [WIDTH-1:0] WrData;
    logic             ReadHiLo;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic             Stall;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B, WrHI, WrLO, WrData, ReadHiLo, Flush,
        input  Busy, Done, Stall, HI, LO
    );

    modport slave (
        input  Start, Op, A, B, WrHI, WrLO, WrData, ReadHiLo, Flush,
        output Busy, Done, Stall, HI, LO
    );
endinterface

// File: rtl/hilo_muldiv_unit_muldiv_step.sv
// One combinational radix-2 iteration: shift-add for multiply, restoring
// subtract-and-shift for divide. {hi,lo} is the shared working register.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;
    logic           unused_trial_msb;

    // trial < divisor whenever fits is set, so its top bit is always zero.
    assign unused_trial_msb = trial[WIDTH];

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, divisor_i} : '0);
        shifted = {hi_i, lo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        fits    = (shifted >= {1'b0, divisor_i});

        if (is_div_i) begin
            hi_o = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], fits};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning the architectural HI/LO pair.
// IDLE latches magnitudes, RUN iterates UNROLL steps per cycle, FIX commits.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    hilo_muldiv_unit_if.slave bus
);
    localparam int               N       = WIDTH / UNROLL;
    localparam int               CNT_W   = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH % 2) != 0 || WIDTH < 8 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("hilo_muldiv_unit: WIDTH must be even and in 8..MAX_WIDTH");
    end
    if (!(UNROLL inside {1, 2, 4}) || (WIDTH % UNROLL) != 0) begin : g_bad_unroll
        $error("hilo_muldiv_unit: UNROLL must be 1, 2 or 4 and divide WIDTH");
    end

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;

    logic [UNROLL:0][WIDTH-1:0] chain_hi;
    logic [UNROLL:0][WIDTH-1:0] chain_lo;
    logic                       run_div;

    assign run_div     = is_div_op(op_q);
    assign chain_hi[0] = acc_hi_q;
    assign chain_lo[0] = acc_lo_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_div_i  (run_div),
            .hi_i      (chain_hi[i]),
            .lo_i      (chain_lo[i]),
            .divisor_i (mag_b_q),
            .hi_o      (chain_hi[i+1]),
            .lo_o      (chain_lo[i+1])
        );
    end

    // Result formation in FIX: sign fix-up, divide special cases, accumulate.
    logic                 op_signed;
    logic                 neg_result;
    logic [2*WIDTH-1:0]   prod_mag;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   fix_acc;

    always_comb begin
        op_signed  = is_signed_op(op_q);
        neg_result = op_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        prod_mag   = {acc_hi_q, acc_lo_q};
        prod       = neg_result ? -prod_mag : prod_mag;
        quot       = neg_result ? -acc_lo_q : acc_lo_q;
        rem        = (op_signed && a_q[WIDTH-1]) ? -acc_hi_q : acc_hi_q;
        fix_acc    = prod;

        case (op_q)
            OP_MADD: fix_acc = {hi_q, lo_q} + prod;
            OP_MSUB: fix_acc = {hi_q, lo_q} - prod;
            OP_DIV, OP_DIVU: begin
                if (b_q == '0) begin
                    fix_acc = {a_q, DIV0_LO[WIDTH-1:0]};
                end else if (op_q == OP_DIV && a_q == MIN_VAL && b_q == '1) begin
                    fix_acc = {{WIDTH{1'b0}}, MIN_VAL};
                end else begin
                    fix_acc = {rem, quot};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        count_d  = count_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mag_b_d  = mag_b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.WrHI) hi_d = bus.WrData;
                if (bus.WrLO) lo_d = bus.WrData;
                if (bus.Start && bus.Op <= OP_MSUB) begin
                    state_d  = ST_RUN;
                    count_d  = CNT_W'(N);
                    op_d     = bus.Op;
                    a_d      = bus.A;
                    b_d      = bus.B;
                    acc_hi_d = '0;
                    acc_lo_d = (is_signed_op(bus.Op) && bus.A[WIDTH-1]) ? -bus.A : bus.A;
                    mag_b_d  = (is_signed_op(bus.Op) && bus.B[WIDTH-1]) ? -bus.B : bus.B;
                end
            end
            ST_RUN: begin
                acc_hi_d = chain_hi[UNROLL];
                acc_lo_d = chain_lo[UNROLL];
                count_d  = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) state_d = ST_FIX;
                if (bus.Flush)            state_d = ST_IDLE;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.Flush) begin
                    {hi_d, lo_d} = fix_acc;
                    done_d       = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: operand and working registers are deliberately not reset; IDLE
    // always reloads them before RUN reads them.
    always_ff @(posedge Clk) begin
        count_q  <= count_d;
        op_q     <= op_d;
        a_q      <= a_d;
        b_q      <= b_d;
        mag_b_q  <= mag_b_d;
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
    end

    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.Stall = busy_q & (bus.Start | bus.ReadHiLo | bus.WrHI | bus.WrLO);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: a vector table drives a scoreboard checked on
// Done, plus hand sequences for flush, reset, stall and back-to-back issue.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           start;
        string        name;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           pre;
        logic [W-1:0] pre_hi;
        logic [W-1:0] pre_lo;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb1[$];
    exp_t sb4[$];
    vec_t vecs[14];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus1 ();
    hilo_muldiv_unit_if #(.WIDTH(W)) bus4 ();

    hilo_muldiv_unit #(.WIDTH(W), .UNROLL(1)) dut1 (.Clk(clk), .Reset(rst), .bus(bus1));
    hilo_muldiv_unit #(.WIDTH(W), .UNROLL(4)) dut4 (.Clk(clk), .Reset(rst), .bus(bus4));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: every Done pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus1.Done) begin
            if (sb1.size() == 0) begin
                check("dut1_spurious_done", 64'(bus1.Done), 64'(0));
            end else begin
                e = sb1.pop_front();
                check({e.name, "_hi"}, bus1.HI, e.hi);
                check({e.name, "_lo"}, bus1.LO, e.lo);
                check({e.name, "_latency"}, 64'(cyc - e.start), 64'(e.lat));
            end
        end
        if (bus4.Done) begin
            if (sb4.size() == 0) begin
                check("dut4_spurious_done", 64'(bus4.Done), 64'(0));
            end else begin
                e = sb4.pop_front();
                check({e.name, "_hi"}, bus4.HI, e.hi);
                check({e.name, "_lo"}, bus4.LO, e.lo);
                check({e.name, "_latency"}, 64'(cyc - e.start), 64'(e.lat));
            end
        end
    end

    task automatic issue1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input string name);
        bus1.Op    = op;
        bus1.A     = a;
        bus1.B     = b;
        bus1.Start = 1'b1;
        if (push) sb1.push_back('{ehi, elo, 34, cyc, name});
        tick();
        bus1.Start = 1'b0;
    endtask

    task automatic drain1();
        int n = 0;
        while (sb1.size() != 0 && n < 80) begin
            tick();
            n++;
        end
        check("drain1", 64'(sb1.size()), 64'(0));
    endtask

    task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        bus1.WrHI   = 1'b1;
        bus1.WrData = h;
        tick();
        bus1.WrHI   = 1'b0;
        bus1.WrLO   = 1'b1;
        bus1.WrData = l;
        tick();
        bus1.WrLO   = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hi0;
        logic [W-1:0] lo0;
        int           n;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg"};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 0, 0, 0, 32'h00000007, 32'hFFFFFFFF, "divu_by0"};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[5]  = '{OP_MADD,  32'h00000003, 32'h00000004, 1, 32'h0, 32'hA, 32'h00000000, 32'h00000016, "madd"};
        vecs[6]  = '{OP_MSUB,  32'h00000005, 32'h00000005, 1, 32'h0, 32'hA, 32'hFFFFFFFF, 32'hFFFFFFF1, "msub"};
        vecs[7]  = '{OP_DIVU,  32'h00000064, 32'h00000003, 0, 0, 0, 32'h00000001, 32'h00000021, "divu_100_3"};
        vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 0, 0, 0, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2"};
        vecs[9]  = '{OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 0, 0, 0, 32'h00000000, 32'h0000001E, "mult_negneg"};
        vecs[10] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000002, 1, 32'h1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFD, "madd_borrow"};
        vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 0, 0, 0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0"};
        vecs[12] = '{OP_MULTU, 32'h80000000, 32'h00000002, 0, 0, 0, 32'h00000001, 32'h00000000, "multu_carry"};
        vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 0, 0, 0, 32'h0000000F, 32'h0FFFFFFF, "divu_big"};

        rst = 1'b1;
        {bus1.Start, bus1.Op, bus1.A, bus1.B, bus1.WrHI, bus1.WrLO, bus1.WrData, bus1.ReadHiLo, bus1.Flush} = '0;
        {bus4.Start, bus4.Op, bus4.A, bus4.B, bus4.WrHI, bus4.WrLO, bus4.WrData, bus4.ReadHiLo, bus4.Flush} = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_hi",    bus1.HI,   0);
        check("reset_lo",    bus1.LO,   0);
        check("reset_busy",  bus1.Busy, 0);
        check("reset_done",  bus1.Done, 0);
        check("reset4_busy", bus4.Busy, 0);

        foreach (vecs[i]) begin
            if (vecs[i].pre) begin
                write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
                check({vecs[i].name, "_pre_hi"}, bus1.HI, vecs[i].pre_hi);
                check({vecs[i].name, "_pre_lo"}, bus1.LO, vecs[i].pre_lo);
            end
            issue1(vecs[i].op, vecs[i].a, vecs[i].b, 1, vecs[i].hi, vecs[i].lo, vecs[i].name);
            if (i == 0) begin
                for (int k = 1; k <= 35; k++) begin
                    @(negedge clk);
                    check($sformatf("busy_cycle%0d", k), bus1.Busy, 64'(k <= 33));
                    tick();
                end
            end
            drain1();
        end

        // UNROLL=4 instance: same MULTU, Done at cycle 10.
        bus4.Op = OP_MULTU; bus4.A = 32'hFFFFFFFF; bus4.B = 32'hFFFFFFFF; bus4.Start = 1'b1;
        sb4.push_back('{32'hFFFFFFFE, 32'h00000001, 10, cyc, "u4_multu"});
        tick();
        bus4.Start = 1'b0;
        n = 0;
        while (sb4.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain4", 64'(sb4.size()), 64'(0));

        // Back-to-back: issue in the Done cycle, ReadHiLo there must not stall.
        issue1(OP_MULTU, 32'd6, 32'd7, 1, 32'h0, 32'h2A, "b2b_first");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.Done && n < 60);
        check("b2b_done_seen", bus1.Done, 1);
        bus1.Op = OP_MULT; bus1.A = 32'd3; bus1.B = 32'hFFFFFFFE;
        bus1.Start = 1'b1; bus1.ReadHiLo = 1'b1;
        sb1.push_back('{32'hFFFFFFFF, 32'hFFFFFFFA, 34, cyc, "b2b_second"});
        #1 check("stall_in_done_cycle", bus1.Stall, 0);
        tick();
        bus1.Start = 1'b0;
        #1 check("stall_readhilo_busy", bus1.Stall, 1);
        bus1.ReadHiLo = 1'b0;
        drain1();

        // Flush at cycle 10 of a DIVU: no commit, no Done.
        hi0 = bus1.HI;
        lo0 = bus1.LO;
        issue1(OP_DIVU, 32'd100, 32'd3, 0, 0, 0, "flush");
        repeat (9) tick();
        bus1.Flush = 1'b1;
        @(negedge clk);
        check("flush_busy_c10", bus1.Busy, 1);
        tick();
        bus1.Flush = 1'b0;
        @(negedge clk);
        check("flush_busy_c11", bus1.Busy, 0);
        check("flush_hi", bus1.HI, hi0);
        check("flush_lo", bus1.LO, lo0);
        repeat (40) tick();
        check("flush_hi_later", bus1.HI, hi0);
        check("flush_lo_later", bus1.LO, lo0);

        // Reset at cycle 20 of a MULT: clears HI/LO, no Done afterwards.
        issue1(OP_MULT, 32'd5, 32'd5, 0, 0, 0, "reset_mid");
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midreset_hi",   bus1.HI,   0);
        check("midreset_lo",   bus1.LO,   0);
        check("midreset_busy", bus1.Busy, 0);
        repeat (40) tick();
        check("midreset_idle", bus1.Busy, 0);

        // WrHI while Busy stalls and is ignored.
        bus1.WrHI = 1'b1; bus1.WrData = 32'h12345678;
        tick();
        bus1.WrHI = 1'b0;
        check("wrhi_idle", bus1.HI, 32'h12345678);
        issue1(OP_MULTU, 32'd6, 32'd7, 1, 32'h0, 32'h2A, "wrhi_busy_op");
        repeat (4) tick();
        bus1.WrHI = 1'b1; bus1.WrData = 32'hDEADBEEF;
        #1 check("stall_wrhi_busy", bus1.Stall, 1);
        tick();
        bus1.WrHI = 1'b0;
        @(negedge clk);
        check("wrhi_busy_ignored", bus1.HI, 32'h12345678);
        drain1();

        // WrLO together with Start: LO written now, MADD accumulates onto it.
        bus1.WrLO = 1'b1; bus1.WrData = 32'h64;
        issue1(OP_MADD, 32'd2, 32'd3, 1, 32'h0, 32'h6A, "wrlo_with_start");
        bus1.WrLO = 1'b0;
        check("wrlo_with_start_lo", bus1.LO, 32'h64);
        drain1();

        check("sb1_empty", 64'(sb1.size()), 64'(0));
        check("sb4_empty", 64'(sb4.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
